// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler that lets several byte-stream
// requesters share a single uart_tx. A requester keeps the transmitter until
// it sends its last element, runs dry, or has sent MAX_BURST elements.
//
// Ports:
//   clk, rst      - clock (posedge) and asynchronous active-high reset
//   req_valid     - per-requester element available
//   req_data      - requester i element at [i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
//   req_last      - per-requester last-element-of-message flag
//   req_ready     - element accepted when req_valid[i] & req_ready[i]
//   tx_en         - one-cycle transmit strobe to uart_tx
//   tx_data       - element to uart_tx, held for the whole frame
//   tx_ready      - uart_tx idle/ready
//   grant_valid   - a requester currently owns the transmitter
//   grant_id      - index of the owning requester (holds while not granted)
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned ELEMENT_WIDTH  = 8,
  parameter int unsigned MAX_BURST      = 16,
  localparam int unsigned IdW           = $clog2(NUM_REQUESTERS)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQUESTERS-1:0]               req_valid,
  input  logic [NUM_REQUESTERS*ELEMENT_WIDTH-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]               req_last,
  output logic [NUM_REQUESTERS-1:0]               req_ready,
  output logic                                    tx_en,
  output logic [ELEMENT_WIDTH-1:0]                tx_data,
  input  logic                                    tx_ready,
  output logic                                    grant_valid,
  output logic [IdW-1:0]                          grant_id
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e                   state_q, state_d;
  logic [ELEMENT_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                     last_flag_q, last_flag_d;
  logic [7:0]               burst_cnt_q, burst_cnt_d;
  logic                     grant_valid_q, grant_valid_d;
  logic [IdW-1:0]           grant_id_q, grant_id_d;
  logic [IdW-1:0]           rr_ptr_q, rr_ptr_d;

  logic                     pick_found;
  logic [IdW-1:0]           pick_id;
  logic [IdW-1:0]           next_id;
  logic                     sel_valid;
  logic                     sel_last;
  logic [ELEMENT_WIDTH-1:0] sel_data;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQUESTERS.
  always_comb begin : rr_pick
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_REQUESTERS;
      if (!pick_found && req_valid[IdW'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = IdW'(idx);
      end
    end
  end

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  assign next_id   = (grant_id_q == IdW'(NUM_REQUESTERS - 1)) ? '0 : grant_id_q + IdW'(1);
  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign sel_data  = req_data[32'(grant_id_q) * ELEMENT_WIDTH +: ELEMENT_WIDTH];

  always_comb begin
    req_ready = '0;
    if (state_q == StLoad) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    last_flag_d   = last_flag_q;
    burst_cnt_d   = burst_cnt_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    case (state_q)
      StIdle: begin
        if (tx_ready && pick_found) begin
          grant_valid_d = 1'b1;
          grant_id_d    = pick_id;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        if (sel_valid) begin
          tx_data_d   = sel_data;
          last_flag_d = sel_last;
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = StIssue;
        end else begin
          // Owner ran dry mid-message: hand the transmitter on.
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_id;
          burst_cnt_d   = '0;
          state_d       = StIdle;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_ready) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (tx_ready) begin
          if (last_flag_q || (burst_cnt_q == 8'(MAX_BURST))) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_id;
            burst_cnt_d   = '0;
            state_d       = StIdle;
          end else begin
            state_d = StLoad;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tx_data_q     <= '0;
      last_flag_q   <= 1'b0;
      burst_cnt_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      last_flag_q   <= last_flag_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign tx_en       = (state_q == StIssue);
  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench for uart_tx_scheduler. Requester
// models feed per-requester element lists, a small uart_tx model answers
// tx_en with a busy frame, and every tx_en strobe is compared against the
// next expected (requester, element) pair.
module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int EW    = 8;
  localparam int MB    = 4;
  localparam int Frame = 3;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*EW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             tx_en;
  logic [EW-1:0]    tx_data;
  logic             tx_ready;
  logic             grant_valid;
  logic [1:0]       grant_id;

  uart_tx_scheduler #(
    .NUM_REQUESTERS(NR),
    .ELEMENT_WIDTH (EW),
    .MAX_BURST     (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Requester element lists: {last, data}.
  logic [8:0]  mem [NR][32];
  int          head [NR] = '{default: 0};
  int          tail [NR] = '{default: 0};
  logic [15:0] exp_q [$];
  bit          stall = 1'b0;

  task automatic add(input int id, input logic [7:0] d, input logic l);
    mem[id][tail[id]] = {l, d};
    tail[id]++;
  endtask

  task automatic sb_push(input int id, input logic [7:0] d);
    exp_q.push_back({8'(id), d});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: acceptance seen before the edge, lists advanced after it.
  initial begin
    logic [NR-1:0] acc;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && !rst) head[i]++;
        req_valid[i]           = (head[i] < tail[i]);
        req_data[i*EW +: EW]   = req_valid[i] ? mem[i][head[i]][7:0] : '0;
        req_last[i]            = req_valid[i] & mem[i][head[i]][8];
      end
    end
  end

  // uart_tx model: busy for Frame cycles after each strobe, longer while stalled.
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_ready = 1'b1;
        busy_cnt = 0;
      end else if (tx_en) begin
        tx_ready = 1'b0;
        busy_cnt = Frame;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end else if (!stall) begin
        tx_ready = 1'b1;
      end
    end
  end

  // Output monitor: every strobe pops one scoreboard entry.
  logic prev_en = 1'b0;
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (tx_en) begin
          check("tx_en_single_cycle", 32'(prev_en), 32'd0);
          if (exp_q.size() == 0) begin
            check("tx_unexpected", 32'(tx_data), 32'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[7:0]));
            check("tx_grant_id", 32'(grant_id), 32'(e[15:8]));
          end
        end
        prev_en = tx_en;
      end
    end
  end

  task automatic drain(input string tag);
    int cyc;
    bit done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      done = (exp_q.size() == 0) && !grant_valid && tx_ready && all_empty();
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic wait_sb(input string tag, input int remaining);
    int cyc;
    cyc = 0;
    while (exp_q.size() > remaining && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_wait"}, 32'(exp_q.size() <= remaining), 32'd1);
  endtask

  initial begin
    int bad_en, bad_data, bad_rdy;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single requester, three-element message.
    add(2, 8'h41, 1'b0); add(2, 8'h42, 1'b0); add(2, 8'h43, 1'b1);
    sb_push(2, 8'h41); sb_push(2, 8'h42); sb_push(2, 8'h43);
    drain("single_req");
    check("idle_grant_valid", 32'(grant_valid), 32'd0);
    check("idle_grant_id_hold", 32'(grant_id), 32'd2);

    // rr_ptr=3: requesters 0 and 1 contend, search wraps to 0 first.
    add(0, 8'hA0, 1'b1); add(1, 8'hB1, 1'b1);
    sb_push(0, 8'hA0); sb_push(1, 8'hB1);
    drain("pair");

    // rr_ptr=2: requester 2 beats requester 0.
    add(0, 8'hC0, 1'b1); add(2, 8'hC2, 1'b1);
    sb_push(2, 8'hC2); sb_push(0, 8'hC0);
    drain("rotate");

    // rr_ptr=1: lone requester 3, leaves rr_ptr=0.
    add(3, 8'h3F, 1'b1);
    sb_push(3, 8'h3F);
    drain("align");

    // Burst limit: requester 0 streams 10 with no last, requester 3 waiting.
    for (int k = 0; k < 10; k++) add(0, 8'(8'hE0 + k), 1'b0);
    add(3, 8'hF0, 1'b0); add(3, 8'hF1, 1'b1);
    for (int k = 0; k < 4; k++) sb_push(0, 8'(8'hE0 + k));
    sb_push(3, 8'hF0); sb_push(3, 8'hF1);
    for (int k = 4; k < 10; k++) sb_push(0, 8'(8'hE0 + k));
    drain("burst");

    // rr_ptr=1: requester 1 runs dry in LOAD, requester 2 takes over.
    add(1, 8'h60, 1'b0); add(2, 8'h62, 1'b1);
    sb_push(1, 8'h60); sb_push(2, 8'h62);
    drain("dry_load");

    // rr_ptr=3: uart_tx stays busy for 5000 cycles after the first strobe.
    stall = 1'b1;
    add(3, 8'h70, 1'b0); add(3, 8'h71, 1'b1);
    sb_push(3, 8'h70); sb_push(3, 8'h71);
    wait_sb("stall", 1);
    bad_en = 0; bad_data = 0; bad_rdy = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (tx_en) bad_en++;
      if (tx_data != 8'h70) bad_data++;
      if (|req_ready) bad_rdy++;
    end
    check("stall_tx_en", 32'(bad_en), 32'd0);
    check("stall_tx_data", 32'(bad_data), 32'd0);
    check("stall_req_ready", 32'(bad_rdy), 32'd0);
    stall = 1'b0;
    drain("stall");

    // rr_ptr=0 -> requester 1 once, leaving rr_ptr=2.
    add(1, 8'h81, 1'b1);
    sb_push(1, 8'h81);
    drain("pre_reset");

    // Reset during WAIT_DONE of requester 2's first element.
    add(2, 8'h90, 1'b0); add(2, 8'h91, 1'b0); add(2, 8'h92, 1'b1);
    sb_push(2, 8'h90);
    wait_sb("mid_frame", 0);
    repeat (2) @(negedge clk);
    check("pre_rst_grant_valid", 32'(grant_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_en", 32'(tx_en), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_grant_valid", 32'(grant_valid), 32'd0);
    check("arst_grant_id", 32'(grant_id), 32'd0);
    for (int i = 0; i < NR; i++) head[i] = tail[i];
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // First grant after reset starts from requester 0, not 3.
    add(0, 8'hA5, 1'b1); add(3, 8'hA6, 1'b1);
    sb_push(0, 8'hA5); sb_push(3, 8'hA6);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
